// File: rtl/window_line_buffer_if.sv
// window_line_buffer_if: pixel-in / window-out handshake bundle for the sliding-window generator
interface window_line_buffer_if #(
   parameter int DW = 16,
   parameter int K  = 5,
   parameter int RW = 3,
   parameter int CW = 3
);
   logic                in_valid;
   logic                in_ready;
   logic [DW-1:0]       in_pixel;
   logic                win_valid;
   logic                win_ready;
   logic [K*K*DW-1:0]   win_data;
   logic [RW-1:0]       win_row;
   logic [CW-1:0]       win_col;
   logic                frame_done;
   modport master (output in_valid, in_pixel, win_ready,
                   input  in_ready, win_valid, win_data, win_row, win_col, frame_done);
   modport slave  (input  in_valid, in_pixel, win_ready,
                   output in_ready, win_valid, win_data, win_row, win_col, frame_done);
endinterface

// File: rtl/window_line_buffer.sv
// window_line_buffer: raster-stream K x K sliding-window generator built on K-1 line buffers
module window_line_buffer #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int K     = 5,
   parameter int DW    = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   window_line_buffer_if.slave bus
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [DW-1:0] lb  [K-1][IMG_W];
   logic [DW-1:0] win [K][K];
   logic [DW-1:0] vec [K];
   logic acc, emit, col_last;
   assign bus.in_ready   = !bus.win_valid | bus.win_ready;
   assign acc            = bus.in_valid & bus.in_ready & !clear;
   assign emit           = acc && row >= RW'(K-1) && col >= CW'(K-1);
   assign col_last       = col == CW'(IMG_W-1);
   assign bus.frame_done = bus.win_valid & bus.win_ready & !clear &
                           bus.win_row == RW'(IMG_H-1) & bus.win_col == CW'(IMG_W-1);
   // new column vector: oldest buffered row on top, incoming pixel at the bottom
   always_comb begin
      for (int r = 0; r < K-1; r++) vec[r] = lb[K-2-r][col];
      vec[K-1] = bus.in_pixel;
   end
   // line buffers shift down one row at the accepted column; contents need no reset
   always_ff @(posedge clk) begin
      if (acc) begin
         for (int i = K-2; i > 0; i--) lb[i][col] <= lb[i-1][col];
         lb[0][col] <= bus.in_pixel;
      end
   end
   // window array shifts left and takes the new column on the right
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win[r][c] <= '0;
      end else if (acc) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) win[r][c] <= win[r][c+1];
            win[r][K-1] <= vec[r];
         end
      end
   end
   // raster counters and the single output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row           <= '0;
         col           <= '0;
         bus.win_valid <= 1'b0;
         bus.win_row   <= '0;
         bus.win_col   <= '0;
      end else if (clear) begin
         row           <= '0;
         col           <= '0;
         bus.win_valid <= 1'b0;
      end else if (acc) begin
         col           <= col_last ? '0 : col + 1'b1;
         if (col_last) row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
         bus.win_valid <= emit;
         if (emit) begin
            bus.win_row <= row;
            bus.win_col <= col;
         end
      end else if (bus.win_ready) begin
         bus.win_valid <= 1'b0;
      end
   end
   // flatten window[r][c] into the bus, row-major
   always_comb begin
      bus.win_data = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) bus.win_data[(r*K+c)*DW +: DW] = win[r][c];
   end
   // a held window must not move until downstream takes it
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      bus.win_valid && !bus.win_ready |=> $stable(bus.win_data));
endmodule
